fetch_unit: RTL and testbench

- Initiator side of the 8-bit-address / 16-bit-data program ROM port: owns the program counter, drives the ROM address and captures the returned word.
- Buffers fetched words in a small prefetch queue and presents them to the decoder over a valid/ready handshake.
- Supports branch redirect with flush, plus halt/resume.
- Sits between the program ROM and the instruction decoder.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_queue.sv | 80 ++++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, fetch state encoding and prefetch queue entry type
package fetch_unit_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular prefetch FIFO of fetch entries with flush, push/pop, full/empty and count
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     push_entry,
    input  logic                       pop,
    output entry_t                     head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program ROM fetch unit with prefetch queue, redirect/flush and halt/resume
// Optional pc wrap trap enabled by defining FETCH_WRAP_TRAP_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00,
    parameter int              DEPTH    = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic [PC_W-1:0]    rom_address,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_addr,
    input  logic               halt_req,
    input  logic               resume,
    output logic               halted,
    output logic               fault
);

    state_e                  state_q, state_d;
    logic [PC_W-1:0]         pc_q, pc_d;
    logic                    q_push;
    logic                    q_flush;
    logic                    q_pop;
    logic                    q_full;
    logic                    q_empty;
    logic [$clog2(DEPTH):0]  q_count;
    entry_t                  q_head;
    entry_t                  q_in;

    assign rom_address = pc_q;
    assign q_in        = '{pc: pc_q, data: rom_data};
    assign instr_valid = !q_empty;
    assign q_pop       = instr_valid && instr_ready;
    // Stale storage behind a flushed queue is masked so the outputs idle at zero.
    assign instr_data  = q_empty ? '0 : q_head.data;
    assign instr_pc    = q_empty ? '0 : q_head.pc;
    assign halted      = (state_q == ST_HALTED) && (q_count == '0);

`ifdef FETCH_WRAP_TRAP_EN
    assign fault = (state_q == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        q_push  = 1'b0;
        q_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    q_flush = 1'b1;
                    pc_d    = redirect_addr;
                    if (halt_req) begin
                        state_d = ST_HALTED;
                    end
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (!q_full || q_pop) begin
                    q_push = 1'b1;
`ifdef FETCH_WRAP_TRAP_EN
                    // The last word before the wrap is still delivered; pc stays put.
                    if (pc_q == '1) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
`else
                    pc_d = pc_q + PC_W'(1);
`endif
                end
            end
            ST_HALTED: begin
                if (redirect) begin
                    q_flush = 1'b1;
                    pc_d    = redirect_addr;
                end else if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (q_flush),
        .push       (q_push),
        .push_entry (q_in),
        .pop        (q_pop),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit: directed phases, monitor checks delivered words
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rom_address;
    logic [15:0] rom_data;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_data;
    logic [7:0]  instr_pc;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_addr = 8'h00;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        halted;
    logic        fault;

    logic [23:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    assign rom_data = 16'hA000 + {8'h00, rom_address};

    fetch_unit #(
        .RESET_PC (8'h00),
        .DEPTH    (DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rom_address   (rom_address),
        .rom_data      (rom_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt_req      (halt_req),
        .resume        (resume),
        .halted        (halted),
        .fault         (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_words(input logic [7:0] start, input int n);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 8'(i);
            exp_q.push_back({a, 16'hA000 + {8'h00, a}});
        end
    endtask

    // Hold ready high until the monitor has matched every queued expectation.
    task automatic consume();
        bit done;
        done = 1'b0;
        instr_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        #1;
        instr_ready = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL consume_timeout: actual %0d words outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clock) begin
        logic [23:0] e;
        if (instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: actual %0h/%0h expected none", instr_pc, instr_data);
            end else begin
                e = exp_q.pop_front();
                if ({instr_pc, instr_data} !== e) begin
                    errors++;
                    $display("FAIL word: actual %0h/%0h expected %0h/%0h", instr_pc, instr_data, e[23:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        check("rst_valid", instr_valid, 0);
        check("rst_data", instr_data, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_rom_address", rom_address, 8'h00);

        // Stream from reset: first word one cycle after release.
        expect_words(8'h00, 6);
        instr_ready = 1'b1;
        reset_n = 1'b1;
        #2;
        check("first_cycle_valid", instr_valid, 0);
        consume();

        // Backpressure: head 0x06 held, pc stops DEPTH words ahead.
        for (int i = 0; i < 5; i++) begin
            check("hold_pc", instr_pc, 8'h06);
            check("hold_data", instr_data, 16'hA006);
            tick();
        end
        check("hold_valid", instr_valid, 1);
        check("full_rom_address", rom_address, 8'(6 + DEPTH));
        expect_words(8'h06, 6);
        consume();

        // Redirect while full.
        repeat (3) tick();
        check("prefull_rom_address", rom_address, 8'(12 + DEPTH));
        redirect = 1'b1;
        redirect_addr = 8'h40;
        tick();
        redirect = 1'b0;
        check("redirect_valid", instr_valid, 0);
        check("redirect_rom_address", rom_address, 8'h40);
        expect_words(8'h40, 5);
        consume();

        // Halt with queue full, drain, then resume.
        repeat (2) tick();
        expect_words(8'h45, DEPTH);
        halt_req = 1'b1;
        instr_ready = 1'b1;
        tick();
        halt_req = 1'b0;
        consume();
        check("halted", halted, 1);
        check("halted_valid", instr_valid, 0);
        check("halted_rom_address", rom_address, 8'(8'h45 + DEPTH));
        repeat (3) tick();
        check("frozen_rom_address", rom_address, 8'(8'h45 + DEPTH));
        expect_words(8'(8'h45 + DEPTH), 4);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resumed_halted", halted, 0);
        consume();

        // Wrap at 0xFF.
        repeat (2) tick();
        redirect = 1'b1;
        redirect_addr = 8'hFE;
        tick();
        redirect = 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
        expect_words(8'hFE, 2);
        consume();
        repeat (3) tick();
        check("trap_fault", fault, 1);
        check("trap_valid", instr_valid, 0);
        instr_ready = 1'b1;
        repeat (3) tick();
        instr_ready = 1'b0;
`else
        expect_words(8'hFE, 4);
        consume();
        check("wrap_fault", fault, 0);
`endif
        repeat (2) tick();

        // Asynchronous reset mid-stream discards the queue.
        reset_n = 1'b0;
        #1;
        check("midrst_valid", instr_valid, 0);
        check("midrst_rom_address", rom_address, 8'h00);
        check("midrst_fault", fault, 0);
        tick();
        expect_words(8'h00, 3);
        instr_ready = 1'b1;
        reset_n = 1'b1;
        consume();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
